// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN to receive and check a parity bit after the data bits.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          rx,
    input  logic                          flush,
    output logic [DATA_BITS-1:0]          data,
    output logic                          valid,
    input  logic                          ready,
    output logic                          framing_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
`ifdef UART_RX_PARITY_EN
    localparam int WW = DATA_BITS + 2;
`else
    localparam int WW = DATA_BITS + 1;
`endif

    localparam logic [CW-1:0] MID_LO    = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] MID       = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] MID_HI    = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_s1_q, rx_s1_d;
    logic                  rx_s2_q, rx_s2_d;
    logic                  rx_prev_q, rx_prev_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            ones_q, ones_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                  perr_q, perr_d;
`endif

    logic [WW-1:0]         mem_q [FIFO_DEPTH];
    logic [WW-1:0]         mem_d [FIFO_DEPTH];
    logic [AW-1:0]         wr_q, wr_d;
    logic [AW-1:0]         rd_q, rd_d;
    logic [NW-1:0]         count_q, count_d;
    logic                  ovr_q, ovr_d;

    logic                  sample, decide, bit_end, vote;
    logic                  push, pop, full, wr_en;
    logic [WW-1:0]         word;

    always_comb begin
        rx_s1_d   = rx;
        rx_s2_d   = rx_s1_q;
        rx_prev_d = rx_s2_q;
    end

    // Third vote is the live sample, so the majority is known on that cycle.
    always_comb begin
        sample  = (cnt_q == MID_LO) || (cnt_q == MID) || (cnt_q == MID_HI);
        decide  = (cnt_q == MID_HI);
        bit_end = (cnt_q == LAST_CNT);
        vote    = ones_q[1] | (ones_q[0] & rx_s2_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
        ones_d  = ones_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ferr_d  = ferr_q;
        push    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
        word    = {perr_q, ferr_q | ~vote, shreg_q};
`else
        word    = {ferr_q | ~vote, shreg_q};
`endif
        if (sample) ones_d = ones_q + {1'b0, rx_s2_q};
        if (decide) ones_d = '0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                ones_d = '0;
                if (rx_prev_q && !rx_s2_q) begin
                    state_d = START;
                    bit_d   = '0;
                    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr_d  = 1'b0;
`endif
                end
            end
            START: begin
                if (decide && vote) state_d = IDLE;
                else if (bit_end)   state_d = DATA;
            end
            DATA: begin
                if (decide) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    bit_d = bit_q + BW'(1);
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (decide)
                    perr_d = (^{shreg_q, vote}) != 1'(PARITY_ODD);
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (decide) begin
                    if (!vote) ferr_d = 1'b1;
                    if (bit_q == LAST_STOP) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end else if (bit_end) begin
                    bit_d = bit_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop     = valid && ready;
        full    = count_q == NW'(FIFO_DEPTH);
        wr_en   = 1'b0;
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        ovr_d   = ovr_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
            ovr_d   = 1'b0;
        end else begin
            wr_en = push && (!full || pop);
            if (wr_en) begin
                mem_d[wr_q] = word;
                wr_d        = wr_q + AW'(1);
            end
            if (push && full && !pop) ovr_d = 1'b1;
            if (pop) rd_d = rd_q + AW'(1);
            count_d = count_q + NW'(wr_en) - NW'(pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            ones_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
            mem_q     <= '{default: '0};
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_s1_q   <= rx_s1_d;
            rx_s2_q   <= rx_s2_d;
            rx_prev_q <= rx_prev_d;
            cnt_q     <= cnt_d;
            ones_q    <= ones_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
`endif
            mem_q     <= mem_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            ovr_q     <= ovr_d;
        end
    end

    assign valid       = count_q != '0;
    assign data        = mem_q[rd_q][DATA_BITS-1:0];
    assign framing_err = valid & mem_q[rd_q][DATA_BITS];
`ifdef UART_RX_PARITY_EN
    assign parity_err  = valid & mem_q[rd_q][DATA_BITS+1];
`else
    assign parity_err  = 1'b0;
`endif
    assign overrun     = ovr_q;
    assign busy        = state_q != IDLE;
    assign fifo_count  = count_q;

endmodule
